// File: rtl/run_detector.sv
// Run-length detector: flags thresh consecutive identical valid bits.
// Level or retriggering pulse output, with a saturating hit counter.
module run_detector #(
    parameter int CW     = 4,
    parameter int HW     = 8,
    parameter int RETRIG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    input  logic          in_valid,
    input  logic          clr,
    input  logic [CW-1:0] thresh,
    input  logic [1:0]    mode,
    output logic          out,
    output logic          hit,
    output logic [CW-1:0] run_len,
    output logic          run_bit,
    output logic [HW-1:0] hit_count
);

    localparam logic [CW-1:0] LEN_MAX = '1;
    localparam logic [HW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] LEN_ONE = CW'(1);

    logic          nbit;
    logic [CW-1:0] nlen;
    logic          match;
    logic          det;
    logic          n_out;
    logic          n_hit;
    logic          n_bit;
    logic [CW-1:0] n_len;
    logic [HW-1:0] n_cnt;

    always_comb begin
        nbit  = in;
        nlen  = LEN_ONE;
        match = 1'b0;
        det   = 1'b0;
        n_out = out;
        n_hit = 1'b0;
        n_bit = run_bit;
        n_len = run_len;
        n_cnt = hit_count;

        if (run_len != '0 && in == run_bit) begin
            nbit = run_bit;
            nlen = (run_len == LEN_MAX) ? LEN_MAX : run_len + LEN_ONE;
        end

        case (mode)
            2'b00:   match = ~nbit;
            2'b01:   match = nbit;
            2'b10:   match = 1'b1;
            default: match = 1'b0;
        endcase

        if (RETRIG == 0)
            det = match && thresh != '0 && nlen >= thresh;
        else
            det = match && thresh != '0 && nlen == thresh;

        if (in_valid) begin
            n_out = det;
            n_bit = nbit;
            if (RETRIG == 0) begin
                n_hit = det & ~out;
                n_len = nlen;
            end else begin
                n_hit = det;
                // a completed run restarts so detections never overlap
                n_len = det ? '0 : nlen;
            end
        end else if (RETRIG != 0) begin
            n_out = 1'b0;
        end

        if (n_hit && hit_count != CNT_MAX)
            n_cnt = hit_count + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out       <= 1'b0;
            hit       <= 1'b0;
            run_len   <= '0;
            run_bit   <= 1'b0;
            hit_count <= '0;
        end else begin
            out       <= n_out;
            hit       <= n_hit;
            run_len   <= n_len;
            run_bit   <= n_bit;
            hit_count <= n_cnt;
        end
    end

endmodule

// File: tb/tb_run_detector.sv
// Scoreboard bench for run_detector: level, retrigger and HW=2 variants
// share one stimulus stream and are checked against a behavioural model.
module tb_run_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] thresh = 4'd3;
    logic [1:0] mode = 2'b00;

    logic       o0, o1, o2;
    logic       h0, h1, h2;
    logic [3:0] l0, l1, l2;
    logic       b0, b1, b2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int len;
        bit b;
        bit o;
        bit h;
        int cnt;
    } st_t;

    typedef struct {
        st_t d[3];
    } exp_t;

    exp_t q[$];
    st_t  cur[3];

    always #5 clk = ~clk;

    run_detector #(.CW(4), .HW(8), .RETRIG(0)) dut0 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
        .thresh(thresh), .mode(mode), .out(o0), .hit(h0),
        .run_len(l0), .run_bit(b0), .hit_count(c0)
    );

    run_detector #(.CW(4), .HW(8), .RETRIG(1)) dut1 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
        .thresh(thresh), .mode(mode), .out(o1), .hit(h1),
        .run_len(l1), .run_bit(b1), .hit_count(c1)
    );

    run_detector #(.CW(4), .HW(2), .RETRIG(0)) dut2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr(clr),
        .thresh(thresh), .mode(mode), .out(o2), .hit(h2),
        .run_len(l2), .run_bit(b2), .hit_count(c2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic st_t model(input st_t s, input bit rt,
                                  input int hmax);
        st_t n;
        int  nl;
        bit  nb, m, d;
        n = s;
        if (rst || clr) begin
            n = '{0, 0, 0, 0, 0};
            return n;
        end
        if (!in_valid) begin
            n.h = 0;
            if (rt) n.o = 0;
            return n;
        end
        if (s.len == 0 || in != s.b) begin
            nl = 1;
            nb = in;
        end else begin
            nb = s.b;
            nl = (s.len < 15) ? s.len + 1 : 15;
        end
        m = (mode == 2) || (mode == 0 && !nb) || (mode == 1 && nb);
        if (!rt) begin
            d     = m && thresh != 0 && nl >= int'(thresh);
            n.h   = d && !s.o;
            n.o   = d;
            n.len = nl;
        end else begin
            d     = m && thresh != 0 && nl == int'(thresh);
            n.h   = d;
            n.o   = d;
            n.len = d ? 0 : nl;
        end
        n.b = nb;
        if (n.h && n.cnt < hmax) n.cnt++;
        return n;
    endfunction

    task automatic compare();
        exp_t e;
        if (q.size() == 0) begin
            chk("queue_empty", 0, 1);
            return;
        end
        e = q.pop_front();
        chk("d0_out", int'(o0), int'(e.d[0].o));
        chk("d0_hit", int'(h0), int'(e.d[0].h));
        chk("d0_len", int'(l0), e.d[0].len);
        chk("d0_bit", int'(b0), int'(e.d[0].b));
        chk("d0_cnt", int'(c0), e.d[0].cnt);
        chk("d1_out", int'(o1), int'(e.d[1].o));
        chk("d1_hit", int'(h1), int'(e.d[1].h));
        chk("d1_len", int'(l1), e.d[1].len);
        chk("d1_bit", int'(b1), int'(e.d[1].b));
        chk("d1_cnt", int'(c1), e.d[1].cnt);
        chk("d2_out", int'(o2), int'(e.d[2].o));
        chk("d2_hit", int'(h2), int'(e.d[2].h));
        chk("d2_len", int'(l2), e.d[2].len);
        chk("d2_bit", int'(b2), int'(e.d[2].b));
        chk("d2_cnt", int'(c2), e.d[2].cnt);
    endtask

    task automatic step(input bit r, input bit c, input bit v,
                        input bit i);
        exp_t e;
        rst      = r;
        clr      = c;
        in_valid = v;
        in       = i;
        cur[0]   = model(cur[0], 0, 255);
        cur[1]   = model(cur[1], 1, 255);
        cur[2]   = model(cur[2], 0, 3);
        e.d      = cur;
        q.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic bit_in(input bit i);
        step(0, 0, 1, i);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) cur[k] = '{0, 0, 0, 0, 0};
        #2;
        // reset, then zeros run
        thresh = 4'd3;
        mode   = 2'b00;
        step(1, 0, 1, 1);
        chk("rst_len", int'(l0), 0);
        chk("rst_out", int'(o0), 0);
        bit_in(0); bit_in(0); bit_in(0);
        chk("run3_out", int'(o0), 1);
        bit_in(0); bit_in(1);
        chk("run_cnt", int'(c0), 1);
        chk("run_drop", int'(o0), 0);

        // either-value mode
        step(0, 1, 0, 0);
        mode = 2'b10;
        for (int k = 0; k < 6; k++) bit_in(k < 3);
        chk("either_cnt", int'(c0), 2);

        // retrigger
        step(0, 1, 0, 0);
        mode   = 2'b01;
        thresh = 4'd2;
        for (int k = 0; k < 7; k++) bit_in(1);
        chk("retrig_cnt", int'(c1), 3);

        // gaps then clear together with valid
        step(0, 1, 0, 0);
        mode   = 2'b00;
        thresh = 4'd3;
        bit_in(0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        bit_in(0); bit_in(0);
        chk("gap_out", int'(o0), 1);
        step(0, 1, 1, 0);
        chk("clr_len", int'(l0), 0);

        // saturation
        thresh = 4'd15;
        for (int k = 0; k < 20; k++) bit_in(0);
        chk("sat_len", int'(l0), 15);
        chk("sat_cnt", int'(c0), 1);

        // disabled by thresh=0, then mode=11
        step(0, 1, 0, 0);
        thresh = 4'd0;
        for (int k = 0; k < 20; k++) bit_in(0);
        thresh = 4'd3;
        mode   = 2'b11;
        for (int k = 0; k < 8; k++) bit_in(k[2]);
        chk("off_cnt", int'(c0), 0);

        // thresh=1 alternating: five detections saturate HW=2
        step(0, 1, 0, 0);
        thresh = 4'd1;
        mode   = 2'b01;
        for (int k = 0; k < 9; k++) bit_in(!k[0]);
        chk("hw2_sat", int'(c2), 3);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) thresh = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
